// File: rtl/dds_param_ctrl.sv
// DDS parameter controller: stages key-driven frequency/amplitude/waveform changes and commits
// them glitch-free on a phase-accumulator wrap. Optional sweep feature enabled by DDS_SWEEP_EN.
module dds_param_ctrl #(
    parameter logic [31:0] FW_BASE   = 32'd86,
    parameter int unsigned SWEEP_DIV = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_freq_add,
    input  logic        key_freq_sub,
    input  logic        key_a,
    input  logic        key_wave,
`ifdef DDS_SWEEP_EN
    input  logic        sweep_en,
`endif
    input  logic        phase_wrap,
    output logic [31:0] fword,
    output logic [2:0]  freq_idx,
    output logic [1:0]  amp_sel,
    output logic [1:0]  wave_sel,
    output logic        cfg_upd,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StWaitWrap, StCommit} state_e;

    state_e      state_q;
    logic [2:0]  s_idx_q, s_idx_d, a_idx_q;
    logic [1:0]  s_amp_q, s_amp_d, a_amp_q;
    logic [1:0]  s_wave_q, s_wave_d, a_wave_q;
    logic [31:0] fword_q;
    logic        cfg_upd_q;
    logic        busy_q;
    logic        pending;
    logic        freq_key;
    logic        sweep_tick;

    assign freq_key = key_freq_add | key_freq_sub;
    assign pending  = (s_idx_q != a_idx_q) | (s_amp_q != a_amp_q) | (s_wave_q != a_wave_q);

`ifdef DDS_SWEEP_EN
    localparam int unsigned CntW = (SWEEP_DIV > 2) ? $clog2(SWEEP_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SWEEP_DIV - 1);

    logic [CntW-1:0] sweep_cnt_q;

    assign sweep_tick = sweep_en && (sweep_cnt_q == CntMax);

    always_ff @(posedge clk) begin
        if (rst || !sweep_en) begin
            sweep_cnt_q <= '0;
        end else if (sweep_cnt_q == CntMax) begin
            sweep_cnt_q <= '0;
        end else begin
            sweep_cnt_q <= sweep_cnt_q + 1'b1;
        end
    end
`else
    assign sweep_tick = 1'b0;
`endif

    // Staged next values; an explicit freq key always overrides a sweep step.
    always_comb begin
        s_idx_d  = s_idx_q;
        s_amp_d  = s_amp_q;
        s_wave_d = s_wave_q;
        if (key_freq_add && !key_freq_sub) begin
            if (s_idx_q != 3'd7) s_idx_d = s_idx_q + 3'd1;
        end else if (key_freq_sub && !key_freq_add) begin
            if (s_idx_q != 3'd0) s_idx_d = s_idx_q - 3'd1;
        end else if (!freq_key && sweep_tick) begin
            s_idx_d = s_idx_q + 3'd1;
        end
        if (key_a)    s_amp_d  = s_amp_q + 2'd1;
        if (key_wave) s_wave_d = s_wave_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            s_idx_q   <= '0;
            s_amp_q   <= '0;
            s_wave_q  <= '0;
            a_idx_q   <= '0;
            a_amp_q   <= '0;
            a_wave_q  <= '0;
            fword_q   <= FW_BASE;
            cfg_upd_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            s_idx_q   <= s_idx_d;
            s_amp_q   <= s_amp_d;
            s_wave_q  <= s_wave_d;
            cfg_upd_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pending) begin
                        state_q <= StWaitWrap;
                        busy_q  <= 1'b1;
                    end
                end
                StWaitWrap: begin
                    // Commit the pre-edge staged values; keys on this edge stay pending.
                    if (phase_wrap) begin
                        state_q   <= StCommit;
                        a_idx_q   <= s_idx_q;
                        a_amp_q   <= s_amp_q;
                        a_wave_q  <= s_wave_q;
                        fword_q   <= FW_BASE << s_idx_q;
                        cfg_upd_q <= 1'b1;
                    end
                end
                StCommit: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fword    = fword_q;
    assign freq_idx = a_idx_q;
    assign amp_sel  = a_amp_q;
    assign wave_sel = a_wave_q;
    assign cfg_upd  = cfg_upd_q;
    assign busy     = busy_q;

endmodule
